sw_ingress_port: RTL and testbench

Ingress stage of the switch. It samples the byte-serial packet stream on `data_in`/`sw_enable_in`, buffers whole packets in a store-and-forward FIFO, and reports backpressure on `read_out`. It releases only complete, valid packets to the crossbar/egress logic, each tagged with its destination port taken from the first byte. Malformed or overflowing packets are discarded atomically.

---
 rtl/sw_ingress_port.sv | 221 ++++++++++++++++++++++
 tb/tb_sw_ingress_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_ingress_port.sv
// Switch ingress port: samples byte-serial packets, buffers them store-and-forward,
// and releases only complete packets tagged with their destination port.
// Optional feature macro: SW_DROP_CNT_EN adds a saturating 16-bit drop counter port.
module sw_ingress_port #(
  parameter int DEPTH     = 64,
  parameter int MAX_PKT   = 16,
  parameter int NUM_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data_in,
  input  logic                         sw_enable_in,
  output logic                         read_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_last,
  output logic [$clog2(NUM_PORTS)-1:0] out_port,
  output logic                         drop_pulse
`ifdef SW_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int LW = $clog2(MAX_PKT + 2);

  typedef logic [AW:0] ptr_t;
  localparam ptr_t           PTR_ONE = ptr_t'(1);
  localparam logic [LW-1:0]  LEN_SAT = LW'(MAX_PKT + 1);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_RECV   = 2'd1;
  localparam logic [1:0] W_END    = 2'd2;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_HDR    = 2'd1;
  localparam logic [1:0] R_STREAM = 2'd2;

  // Address bits equal and wrap bits differ.
  function automatic logic is_full(input ptr_t wp, input ptr_t rp);
    return (wp ^ rp) == {1'b1, {AW{1'b0}}};
  endfunction

  logic [7:0]       mem_q [DEPTH];
  logic [DEPTH-1:0] last_q, last_d;
  logic [1:0]       wstate_q, wstate_d;
  logic [1:0]       rstate_q, rstate_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             wr_commit_q, wr_commit_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic             err_q, err_d;
  logic             drop_pulse_q, drop_pulse_d;
  logic             read_out_q, read_out_d;
  logic [PW-1:0]    port_q, port_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             start;
  ptr_t             base;
  ptr_t             prev;
  logic [AW-1:0]    rd_addr;
  logic             rd_last;
  logic             hs;
  ptr_t             occ;
  logic [AW+1:0]    free_space;

  // Write side: speculative writes, then commit or roll back to wr_commit.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned and infers a latch.
    wstate_d     = wstate_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    len_d        = len_q;
    err_d        = err_q;
    last_d       = last_q;
    drop_pulse_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q[AW-1:0];
    start        = 1'b0;
    base         = wr_ptr_q;
    prev         = wr_ptr_q - PTR_ONE;

    case (wstate_q)
      W_IDLE: start = sw_enable_in;
      W_RECV: begin
        if (sw_enable_in) begin
          err_d = err_q | (len_q >= LW'(MAX_PKT)) | is_full(wr_ptr_q, rd_ptr_q);
          if (len_q != LEN_SAT) len_d = len_q + LW'(1);
          if (!err_d) begin
            mem_we                    = 1'b1;
            last_d[wr_ptr_q[AW-1:0]]  = 1'b0;
            wr_ptr_d                  = wr_ptr_q + PTR_ONE;
          end
        end else begin
          wstate_d = W_END;
        end
      end
      W_END: begin
        wstate_d = W_IDLE;
        if (!err_q && len_q >= LW'(2)) begin
          last_d[prev[AW-1:0]] = 1'b1;
          wr_commit_d          = wr_ptr_q;
        end else begin
          wr_ptr_d     = wr_commit_q;
          base         = wr_commit_q;
          drop_pulse_d = 1'b1;
        end
        start = sw_enable_in;
      end
      default: wstate_d = W_IDLE;
    endcase

    // A new packet may begin in IDLE or directly on the END cycle.
    if (start) begin
      wstate_d  = W_RECV;
      len_d     = LW'(1);
      err_d     = is_full(base, rd_ptr_q);
      mem_waddr = base[AW-1:0];
      if (!err_d) begin
        mem_we               = 1'b1;
        last_d[base[AW-1:0]] = 1'b0;
        wr_ptr_d             = base + PTR_ONE;
      end
    end
  end

  assign rd_addr   = rd_ptr_q[AW-1:0];
  assign rd_last   = last_q[rd_addr];
  assign out_valid = (rstate_q != R_IDLE);
  assign hs        = out_valid & out_ready;

  always_comb begin
    rstate_d = rstate_q;
    rd_ptr_d = rd_ptr_q;
    port_d   = port_q;
    case (rstate_q)
      R_IDLE: if (rd_ptr_q != wr_commit_q) rstate_d = R_HDR;
      R_HDR: begin
        if (hs) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          port_d   = mem_q[rd_addr][PW-1:0];
          rstate_d = rd_last ? R_IDLE : R_STREAM;
        end
      end
      R_STREAM: begin
        if (hs) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (rd_last) rstate_d = (rd_ptr_d != wr_commit_q) ? R_HDR : R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Header byte drives the port directly so it is valid from the first output cycle.
  assign out_data = out_valid ? mem_q[rd_addr] : 8'h00;
  assign out_last = out_valid & rd_last;
  assign out_port = (rstate_q == R_HDR) ? mem_q[rd_addr][PW-1:0] : port_q;

  assign occ        = wr_ptr_q - rd_ptr_q;
  assign free_space = (AW+2)'(DEPTH) - {1'b0, occ};
  assign read_out_d = free_space < (AW+2)'(MAX_PKT);

  // NOTE: the data array carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= data_in;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      last_q       <= '0;
      drop_pulse_q <= 1'b0;
      read_out_q   <= 1'b0;
      port_q       <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      err_q        <= err_d;
      last_q       <= last_d;
      drop_pulse_q <= drop_pulse_d;
      read_out_q   <= read_out_d;
      port_q       <= port_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign read_out   = read_out_q;

`ifdef SW_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_pulse_d && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sw_ingress_port.sv
// Directed self-checking bench for sw_ingress_port: single, runt, oversize,
// backpressure and mid-packet reset scenarios with hand-computed expectations.
module tb_sw_ingress_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       sw_enable_in;
  logic       read_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_port;
  logic       drop_pulse;
`ifdef SW_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  sw_ingress_port #(.DEPTH(64), .MAX_PKT(16), .NUM_PORTS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .sw_enable_in (sw_enable_in),
    .read_out     (read_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_port     (out_port),
    .drop_pulse   (drop_pulse)
`ifdef SW_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fails   = 0;
  int drop_seen = 0;
  logic [7:0] pkt [0:31];

  always @(negedge clk) if (drop_pulse === 1'b1) drop_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives n bytes from pkt[], then one low cycle.
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      sw_enable_in = 1'b1;
      data_in      = pkt[i];
      tick();
    end
    sw_enable_in = 1'b0;
    data_in      = 8'h00;
    tick();
  endtask

  task automatic recv(input int n, input logic [1:0] port, input string tag, output int waited);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, "_wait_valid"}, {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"},  {24'd0, out_data},  {24'd0, pkt[i]});
      check({tag, "_last"},  {31'd0, out_last},  (i == n - 1) ? 32'd1 : 32'd0);
      check({tag, "_port"},  {30'd0, out_port},  {30'd0, port});
      tick();
    end
  endtask

  initial begin
    int waited;
    int total_wait;
    int np;
    int w;

    rst          = 1'b1;
    sw_enable_in = 1'b0;
    data_in      = 8'h00;
    out_ready    = 1'b1;
    tick();
    tick();
    check("rst_valid",    {31'd0, out_valid},  32'd0);
    check("rst_data",     {24'd0, out_data},   32'd0);
    check("rst_last",     {31'd0, out_last},   32'd0);
    check("rst_port",     {30'd0, out_port},   32'd0);
    check("rst_read_out", {31'd0, read_out},   32'd0);
    check("rst_drop",     {31'd0, drop_pulse}, 32'd0);
`ifdef SW_DROP_CNT_EN
    check("rst_drop_cnt", {16'd0, drop_cnt},   32'd0);
`endif
    rst = 1'b0;
    tick();

    // Single packet: bytes sampled at edges t..t+3, out_valid after edge t+6.
    pkt[0] = 8'h02; pkt[1] = 8'hAA; pkt[2] = 8'hBB; pkt[3] = 8'hCC;
    send(4);
    tick();
    check("single_t5_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("single_t6_valid", {31'd0, out_valid}, 32'd1);
    check("single_hdr",      {24'd0, out_data},  32'h02);
    check("single_hdr_port", {30'd0, out_port},  32'd2);
    check("single_hdr_last", {31'd0, out_last},  32'd0);
    tick();
    check("single_b1", {24'd0, out_data}, 32'hAA);
    check("single_b1_last", {31'd0, out_last}, 32'd0);
    tick();
    check("single_b2", {24'd0, out_data}, 32'hBB);
    tick();
    check("single_b3", {24'd0, out_data}, 32'hCC);
    check("single_b3_last", {31'd0, out_last}, 32'd1);
    check("single_b3_port", {30'd0, out_port}, 32'd2);
    tick();
    check("single_done_valid", {31'd0, out_valid}, 32'd0);
    check("single_no_drop", drop_seen, 32'd0);

    // Runt: one byte, drop pulse at edge t+2 only.
    sw_enable_in = 1'b1;
    data_in      = 8'h01;
    tick();
    sw_enable_in = 1'b0;
    data_in      = 8'h00;
    tick();
    check("runt_t1_drop", {31'd0, drop_pulse}, 32'd0);
    tick();
    check("runt_t2_drop", {31'd0, drop_pulse}, 32'd1);
    tick();
    check("runt_t3_drop",  {31'd0, drop_pulse}, 32'd0);
    check("runt_valid",    {31'd0, out_valid},  32'd0);
    check("runt_drop_seen", drop_seen, 32'd1);
`ifdef SW_DROP_CNT_EN
    check("runt_drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif

    // Oversize 17 bytes, then a 3-byte packet after a single low cycle.
    for (int i = 0; i < 17; i++) pkt[i] = 8'h40 + 8'(i);
    send(17);
    check("oversize_valid", {31'd0, out_valid}, 32'd0);
    pkt[0] = 8'h07; pkt[1] = 8'h11; pkt[2] = 8'h22;
    send(3);
    recv(3, 2'd3, "after_oversize", waited);
    check("after_oversize_idle", {31'd0, out_valid}, 32'd0);
    check("oversize_drop_seen", drop_seen, 32'd2);
`ifdef SW_DROP_CNT_EN
    check("oversize_drop_cnt", {16'd0, drop_cnt}, 32'd2);
`endif

    // Backpressure: fill with 16-byte packets until read_out rises.
    out_ready = 1'b0;
    np = 0;
    while (read_out == 1'b0 && np < 8) begin
      for (int i = 0; i < 16; i++) pkt[i] = (i == 0) ? 8'(np) : 8'((np << 4) | i);
      send(16);
      np++;
    end
    check("bp_packets_sent", np, 32'd4);
    check("bp_read_out",     {31'd0, read_out},  32'd1);
    tick();
    tick();
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_data",  {24'd0, out_data},  32'h00);
    check("bp_hold_port",  {30'd0, out_port},  32'd0);
    check("bp_read_out_hold", {31'd0, read_out}, 32'd1);
    out_ready  = 1'b1;
    total_wait = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) pkt[i] = (i == 0) ? 8'(p) : 8'((p << 4) | i);
      recv(16, 2'(p), "bp_drain", waited);
      total_wait += waited;
    end
    check("bp_no_bubbles", total_wait, 32'd0);
    tick();
    tick();
    check("bp_drained_valid", {31'd0, out_valid}, 32'd0);
    check("bp_read_out_fall", {31'd0, read_out},  32'd0);

    // Reset during byte 3 of a packet while a committed packet is stalled.
    out_ready = 1'b0;
    pkt[0] = 8'h01; pkt[1] = 8'h55; pkt[2] = 8'h66;
    send(3);
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("rstmid_stalled_valid", {31'd0, out_valid}, 32'd1);
    sw_enable_in = 1'b1;
    data_in      = 8'h03;
    tick();
    data_in = 8'h33;
    tick();
    data_in = 8'h44;
    rst     = 1'b1;
    tick();
    check("rstmid_valid",    {31'd0, out_valid},  32'd0);
    check("rstmid_data",     {24'd0, out_data},   32'd0);
    check("rstmid_last",     {31'd0, out_last},   32'd0);
    check("rstmid_port",     {30'd0, out_port},   32'd0);
    check("rstmid_read_out", {31'd0, read_out},   32'd0);
    check("rstmid_drop",     {31'd0, drop_pulse}, 32'd0);
`ifdef SW_DROP_CNT_EN
    check("rstmid_drop_cnt", {16'd0, drop_cnt},   32'd0);
`endif
    rst          = 1'b0;
    sw_enable_in = 1'b0;
    data_in      = 8'h00;
    tick();
    tick();
    tick();
    check("rstmid_flushed",   {31'd0, out_valid}, 32'd0);
    check("rstmid_drop_seen", drop_seen, 32'd2);

    out_ready = 1'b1;
    pkt[0] = 8'h02; pkt[1] = 8'h99;
    send(2);
    recv(2, 2'd2, "post_reset", waited);
    check("post_reset_idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
